// File: rtl/cpu_pkg.sv
// Shared CPU constants: fetch state encoding, PC width and instruction field widths.
package cpu_pkg;

    localparam int PC_W   = 32;
    localparam int IMM_W  = 16;
    localparam int JIDX_W = 26;

    typedef enum logic [1:0] {
        FETCH_BOOT  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_FAULT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: redirect priority mux, target arithmetic
// and fetch-target legality check against the instruction memory size.
module pc_next_sel
    import cpu_pkg::*;
#(
    parameter int IMEM_BYTES = 64
) (
    input  logic [PC_W-1:0]   pc,
    input  logic              branch_taken,
    input  logic [IMM_W-1:0]  branch_offset,
    input  logic              jump_en,
    input  logic [JIDX_W-1:0] jump_index,
    input  logic              jr_en,
    input  logic [PC_W-1:0]   jr_target,
    output logic [PC_W-1:0]   pc_plus4,
    output logic [PC_W-1:0]   next_pc,
    output logic              target_illegal
);

    localparam logic [PC_W-1:0] LAST_WORD = 32'(IMEM_BYTES - 4);

    logic [PC_W-1:0] branch_disp;

    assign pc_plus4    = pc + 32'd4;
    assign branch_disp = {{(PC_W-IMM_W-2){branch_offset[IMM_W-1]}}, branch_offset, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jr_en) begin
            next_pc = jr_target;
        end else if (jump_en) begin
            next_pc = {pc_plus4[31:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + branch_disp;
        end
    end

    // Running off the last word is illegal too; the PC never wraps silently.
    assign target_illegal = (next_pc[1:0] != 2'b00) || (next_pc > LAST_WORD);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: PC register, BOOT/RUN/FAULT sequencing and sticky fault.
// Optional macro PC_FETCH_COUNT_EN adds a saturating fetch_count output.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump_en,
    input  logic [25:0] jump_index,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    output logic [31:0] I_mem_addr,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        addr_fault
`ifdef PC_FETCH_COUNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] next_pc;
    logic            target_illegal;

    assign I_mem_addr = pc;

    pc_next_sel #(
        .IMEM_BYTES (IMEM_BYTES)
    ) u_next_sel (
        .pc             (pc),
        .branch_taken   (branch_taken),
        .branch_offset  (branch_offset),
        .jump_en        (jump_en),
        .jump_index     (jump_index),
        .jr_en          (jr_en),
        .jr_target      (jr_target),
        .pc_plus4       (pc_plus4),
        .next_pc        (next_pc),
        .target_illegal (target_illegal)
    );

    // An illegal target leaves the PC on the last good fetch address for debug.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= PC_RESET;
            state       <= FETCH_BOOT;
            fetch_valid <= 1'b0;
            addr_fault  <= 1'b0;
        end else begin
            case (state)
                FETCH_BOOT: begin
                    state       <= FETCH_RUN;
                    fetch_valid <= 1'b1;
                end
                FETCH_RUN: begin
                    if (!stall) begin
                        if (target_illegal) begin
                            state       <= FETCH_FAULT;
                            fetch_valid <= 1'b0;
                            addr_fault  <= 1'b1;
                        end else begin
                            pc <= next_pc;
                        end
                    end
                end
                FETCH_FAULT: begin
                end
                default: begin
                    state       <= FETCH_FAULT;
                    fetch_valid <= 1'b0;
                    addr_fault  <= 1'b1;
                end
            endcase
        end
    end

`ifdef PC_FETCH_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 32'd0;
        end else if (state == FETCH_RUN && !stall && !target_illegal &&
                     fetch_count != 32'hFFFF_FFFF) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized
// redirects against an address-arithmetic reference model.
module tb_pc_fetch_unit;

    localparam int IMEM_BYTES = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_offset = 16'd0;
    logic        jump_en = 1'b0;
    logic [25:0] jump_index = 26'd0;
    logic        jr_en = 1'b0;
    logic [31:0] jr_target = 32'd0;
    logic [31:0] I_mem_addr;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        addr_fault;
`ifdef PC_FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    int total = 0;
    int bad = 0;

    // Reference model: mode 0 = boot, 1 = run, 2 = fault
    longint m_pc;
    int     m_mode;
    longint m_count;

    pc_fetch_unit #(
        .PC_RESET   (32'h0000_0000),
        .IMEM_BYTES (IMEM_BYTES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump_en       (jump_en),
        .jump_index    (jump_index),
        .jr_en         (jr_en),
        .jr_target     (jr_target),
        .I_mem_addr    (I_mem_addr),
        .pc_plus4      (pc_plus4),
        .fetch_valid   (fetch_valid),
        .addr_fault    (addr_fault)
`ifdef PC_FETCH_COUNT_EN
        ,
        .fetch_count   (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic longint model_target();
        longint t;
        if (jr_en)
            t = longint'(jr_target);
        else if (jump_en)
            t = ((m_pc + 4) / 268435456) * 268435456 + longint'(jump_index) * 4;
        else if (branch_taken)
            t = m_pc + 4 + longint'($signed(branch_offset)) * 4;
        else
            t = m_pc + 4;
        return t & 64'hFFFF_FFFF;
    endfunction

    task automatic idle_inputs();
        stall = 1'b0; branch_taken = 1'b0; branch_offset = 16'd0;
        jump_en = 1'b0; jump_index = 26'd0; jr_en = 1'b0; jr_target = 32'd0;
    endtask

    // One clock edge; the model follows the same inputs, outputs settle by +1
    task automatic tick();
        longint t;
        @(posedge clk);
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1 && !stall) begin
            t = model_target();
            if (t % 4 == 0 && t <= IMEM_BYTES - 4) begin
                m_pc = t;
                if (m_count < 64'hFFFF_FFFF) m_count++;
            end else begin
                m_mode = 2;
            end
        end
        #1;
    endtask

    // Assert reset away from the clock edge; caller checks, then releases
    task automatic assert_reset();
        #2;
        rst_n = 1'b0;
        m_pc = 0; m_mode = 0; m_count = 0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        assert_reset();
        total++;
        if ({I_mem_addr, pc_plus4, fetch_valid, addr_fault} !== {32'd0, 32'd4, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL reset_values: addr=%0d plus4=%0d fv=%b af=%b required 0 4 0 0",
                     I_mem_addr, pc_plus4, fetch_valid, addr_fault);
        end
        release_reset();
        total++;
        if ({I_mem_addr, fetch_valid, addr_fault} !== {32'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL boot_state: addr=%0d fv=%b af=%b required 0 0 0",
                     I_mem_addr, fetch_valid, addr_fault);
        end
    endtask

    task automatic test_free_run();
        tick();
        total++;
        if ({I_mem_addr, fetch_valid} !== {32'd0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL first_run: addr=%0d fv=%b required 0 1", I_mem_addr, fetch_valid);
        end
        for (int i = 1; i <= 14; i++) begin
            tick();
            total++;
            if ({I_mem_addr, pc_plus4, fetch_valid, addr_fault} !== {32'(4 * i), 32'(4 * i + 4), 1'b1, 1'b0}) begin
                bad++;
                $display("[TB] FAIL seq_step: addr=%0d plus4=%0d fv=%b af=%b required %0d %0d 1 0",
                         I_mem_addr, pc_plus4, fetch_valid, addr_fault, 4 * i, 4 * i + 4);
            end
        end
`ifdef PC_FETCH_COUNT_EN
        total++;
        if (fetch_count !== 32'd14) begin
            bad++;
            $display("[TB] FAIL count_free_run: got %0d required 14", fetch_count);
        end
`endif
    endtask

    task automatic test_jump_and_fault();
        jump_en = 1'b1; jump_index = 26'd15;
        tick();
        idle_inputs();
        total++;
        if ({I_mem_addr, fetch_valid, addr_fault} !== {32'd60, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL jump_last_word: addr=%0d fv=%b af=%b required 60 1 0",
                     I_mem_addr, fetch_valid, addr_fault);
        end
        branch_taken = 1'b1; branch_offset = 16'd1;
        tick();
        total++;
        if ({I_mem_addr, fetch_valid, addr_fault} !== {32'd60, 1'b0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL branch_fault: addr=%0d fv=%b af=%b required 60 0 1",
                     I_mem_addr, fetch_valid, addr_fault);
        end
        for (int i = 0; i < 4; i++) begin
            jr_en = i[0]; jr_target = 32'd8; jump_en = 1'b1; jump_index = 26'd2;
            branch_taken = 1'b1; branch_offset = 16'hFFFE;
            tick();
            total++;
            if ({I_mem_addr, fetch_valid, addr_fault} !== {32'd60, 1'b0, 1'b1}) begin
                bad++;
                $display("[TB] FAIL fault_sticky: addr=%0d fv=%b af=%b required 60 0 1",
                         I_mem_addr, fetch_valid, addr_fault);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_in_fault();
        assert_reset();
        total++;
        if ({I_mem_addr, fetch_valid, addr_fault} !== {32'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL reset_from_fault: addr=%0d fv=%b af=%b required 0 0 0",
                     I_mem_addr, fetch_valid, addr_fault);
        end
`ifdef PC_FETCH_COUNT_EN
        total++;
        if (fetch_count !== 32'd0) begin
            bad++;
            $display("[TB] FAIL count_reset: got %0d required 0", fetch_count);
        end
`endif
        release_reset();
        tick();
        tick();
        total++;
        if ({I_mem_addr, fetch_valid, addr_fault} !== {32'd4, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL resume_after_reset: addr=%0d fv=%b af=%b required 4 1 0",
                     I_mem_addr, fetch_valid, addr_fault);
        end
    endtask

    task automatic test_priority();
        tick();
        jr_en = 1'b1; jr_target = 32'd20; jump_en = 1'b1; jump_index = 26'd3;
        branch_taken = 1'b1; branch_offset = 16'd1;
        tick();
        total++;
        if (I_mem_addr !== 32'd20) begin
            bad++;
            $display("[TB] FAIL prio_jr: got %0d required 20", I_mem_addr);
        end
        jr_en = 1'b1; jr_target = 32'd8; jump_en = 1'b0; branch_taken = 1'b0;
        tick();
        jr_en = 1'b0; jump_en = 1'b1; jump_index = 26'd3; branch_taken = 1'b1; branch_offset = 16'd1;
        tick();
        total++;
        if (I_mem_addr !== 32'd12) begin
            bad++;
            $display("[TB] FAIL prio_jump: got %0d required 12", I_mem_addr);
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        longint count_before;
        tick();
        count_before = m_count;
        stall = 1'b1; branch_taken = 1'b1; branch_offset = 16'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({I_mem_addr, fetch_valid} !== {32'd16, 1'b1}) begin
                bad++;
                $display("[TB] FAIL stall_hold: addr=%0d fv=%b required 16 1", I_mem_addr, fetch_valid);
            end
`ifdef PC_FETCH_COUNT_EN
            total++;
            if (fetch_count !== 32'(count_before)) begin
                bad++;
                $display("[TB] FAIL stall_count: got %0d required %0d", fetch_count, count_before);
            end
`endif
        end
        idle_inputs();
        tick();
        total++;
        if (I_mem_addr !== 32'd20) begin
            bad++;
            $display("[TB] FAIL stall_release: got %0d required 20", I_mem_addr);
        end
    endtask

    task automatic test_random();
        int fault_ticks = 0;
        for (int n = 0; n < 400; n++) begin
            if (fault_ticks >= 3 || $urandom_range(0, 60) == 0) begin
                idle_inputs();
                assert_reset();
                release_reset();
                fault_ticks = 0;
            end
            stall        = ($urandom_range(0, 3) == 0);
            jr_en        = ($urandom_range(0, 11) == 0);
            jr_target    = 32'($urandom_range(0, 70));
            jump_en      = ($urandom_range(0, 7) == 0);
            jump_index   = 26'($urandom_range(0, 17));
            branch_taken = ($urandom_range(0, 4) == 0);
            branch_offset = 16'($urandom_range(0, 10)) - 16'd5;
            tick();
            if (m_mode == 2) fault_ticks++;
            total++;
            if ({I_mem_addr, pc_plus4, fetch_valid, addr_fault} !==
                {32'(m_pc), 32'(m_pc + 4), m_mode == 1, m_mode == 2}) begin
                bad++;
                $display("[TB] FAIL random_step %0d: addr=%0d plus4=%0d fv=%b af=%b required %0d %0d %b %b",
                         n, I_mem_addr, pc_plus4, fetch_valid, addr_fault,
                         m_pc, m_pc + 4, m_mode == 1, m_mode == 2);
            end
`ifdef PC_FETCH_COUNT_EN
            total++;
            if (fetch_count !== 32'(m_count)) begin
                bad++;
                $display("[TB] FAIL random_count %0d: got %0d required %0d", n, fetch_count, m_count);
            end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        m_pc = 0; m_mode = 0; m_count = 0;
        #1;
        test_reset();
        test_free_run();
        test_jump_and_fault();
        test_reset_in_fault();
        test_priority();
        test_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter stage directly upstream of the byte-addressed instruction memory read block.
- Holds the PC and drives I_mem_addr; the instruction memory returns IR combinationally in the same cycle.
- Selects the next PC from four sources: sequential, conditional branch, absolute jump, register jump.
- Detects illegal fetch targets and parks the fetch path in a sticky fault state.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 64, instruction memory size in bytes; legal fetch addresses are 0..IMEM_BYTES-4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold PC this cycle; redirect inputs are ignored while high.
- branch_taken  input  1  take a PC-relative branch.
- branch_offset  input  16  signed word offset.
- jump_en  input  1  absolute jump (j).
- jump_index  input  26  jump instruction index.
- jr_en  input  1  register jump.
- jr_target  input  32  register jump target.
- I_mem_addr  output  32  current PC, fed to instruction memory.
- pc_plus4  output  32  I_mem_addr + 4, combinational.
- fetch_valid  output  1  IR at I_mem_addr is a real instruction this cycle.
- addr_fault  output  1  sticky illegal-target flag.

Behaviour:
- Reset is asynchronous and active-low. While rst_n is low:
  - I_mem_addr = PC_RESET
  - state = BOOT
  - fetch_valid = 0
  - addr_fault = 0
- States: BOOT, RUN, FAULT.
- BOOT: lasts exactly one clk edge after rst_n deasserts, then moves to RUN. PC is not updated. fetch_valid = 0.
- RUN:
  - fetch_valid = 1.
  - On each edge with stall = 0, the PC loads next_pc.
  - On each edge with stall = 1, the PC holds and all redirect inputs are ignored.
- next_pc priority is jr_en > jump_en > branch_taken > sequential:
  - jr: jr_target.
  - jump: {pc_plus4[31:28], jump_index, 2'b00}.
  - branch: pc_plus4 + (sign-extended branch_offset << 2). Arithmetic is 32-bit modulo; wrap-around is not flagged by itself but is caught by the range check.
  - sequential: pc_plus4.
- Legality check, applied to next_pc only on non-stalled edges in RUN. A target is illegal if:
  - next_pc[1:0] != 0, or
  - next_pc > IMEM_BYTES-4, compared unsigned.
- On an illegal target:
  - PC holds its current value.
  - state moves to FAULT.
  - addr_fault = 1 from the next cycle onward.
- A sequential fall-through past the last word (next_pc = IMEM_BYTES) is also a fault. There is no silent wrap to 0.
- FAULT:
  - PC frozen, fetch_valid = 0, addr_fault = 1.
  - All inputs ignored; only rst_n exits this state.
- Simultaneous redirects are resolved by the priority above; no error is raised.
- A stall in the same cycle as a redirect drops the redirect. Upstream control must re-present it.
- Reset asserted mid-operation, in any state, immediately restores the reset values of all outputs.
- pc_plus4 is combinational from the PC register and is valid in every state.

Optional Feature:
- Macro: PC_FETCH_COUNT_EN.
- Defined: adds output fetch_count [31:0].
  - Reset to 0.
  - Increments on every edge where state is RUN, stall = 0 and the target is legal.
  - Saturates at 32'hFFFF_FFFF.
  - Holds its value in FAULT.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package (cpu_pkg) holds:
  - state encoding constants FETCH_BOOT=2'd0, FETCH_RUN=2'd1, FETCH_FAULT=2'd2
  - PC width constant
  - instruction field widths (16-bit immediate, 26-bit jump index)
- One natural sub-module: pc_next_sel. It is combinational and holds the priority mux, the target arithmetic and the legality check, and outputs next_pc and target_illegal. The top level keeps the PC register, the state machine and the optional counter.

Test Plan:
- Reset then free-run, no redirects:
  - I_mem_addr = 0 during BOOT and for the first RUN cycle.
  - fetch_valid goes 0 -> 1.
  - I_mem_addr then steps 4, 8, ..., 56.
- At PC = 56, jump_en = 1 with jump_index = 26'd15 -> next PC = 60, fetch_valid stays 1.
- At PC = 60, branch_taken = 1 with branch_offset = 16'd1 -> target 68 is illegal:
  - PC holds at 60.
  - state goes to FAULT.
  - addr_fault = 1 and fetch_valid = 0 from the next cycle.
  - Redirects applied afterwards have no effect.
- At PC = 8, all three redirects asserted (jr_target = 32'd20, jump_index = 26'd3, branch_offset = 16'd1) -> next PC = 20 (jr wins). Repeat without jr_en -> 12.
- At PC = 16, stall = 1 for 3 cycles with branch_taken = 1 -> PC stays 16 and the branch is dropped; once stall releases, PC = 20. With PC_FETCH_COUNT_EN, fetch_count does not advance during the stall.
- rst_n pulsed low asynchronously mid-cycle while in FAULT -> outputs immediately become I_mem_addr = 0, addr_fault = 0, fetch_valid = 0; normal BOOT/RUN sequencing resumes.
